mem_sweep_tester: RTL and testbench
===================================

MEM_SWEEP_TESTER -- requirements
Module: mem_sweep_tester

Interface
REQ-001 SHALL have parameter ADDR_WORDS, default 2048, meaning number of 32-bit words swept (byte range 0..4*ADDR_WORDS-1).
REQ-002 SHALL have parameter SEED, default 32'h00000003, meaning pattern base value.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning max cycles to wait for bus_ready per access.
REQ-004 clk  in  1  system clock; the block has one clock, all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; begins a sweep when idle.
REQ-007 bus_enable  out  1  bus request to the memory.
REQ-008 bus_wr_en  out  1  1 = write, 0 = read.
REQ-009 bus_addr  out  32  byte address, always word-aligned.
REQ-010 bus_wdata  out  32  write data.
REQ-011 bus_be  out  4  byte enables, always 4'b1111 during an access.
REQ-012 bus_rdata  in  32  read data, valid when bus_ready=1.
REQ-013 bus_ready  in  1  access complete.
REQ-014 bus_err  in  1  access faulted, sampled with bus_ready.
REQ-015 log_trigger  out  1  one-cycle request to the hex logger.
REQ-016 log_val  out  32  value to print, stable from trigger until log_busy falls.
REQ-017 log_busy  in  1  logger busy; rises one cycle after log_trigger.
REQ-018 busy  out  1  sweep in progress.
REQ-019 done  out  1  sweep finished; held until next start or rst.
REQ-020 err_count  out  16  mismatches plus bus faults, saturating.

Function
REQ-021 SHALL use states IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, LOG, LOG_W1, LOG_W2, FINAL.
REQ-022 In IDLE, start=1 SHALL clear index, err_count and done, set busy, and go to WR_REQ; start in any other state SHALL be ignored.
REQ-023 Pattern for word i SHALL be SEED + i, 32-bit wrap-around; address SHALL be i*4.
REQ-024 WR_REQ SHALL drive bus_enable=1, bus_wr_en=1, bus_be=4'b1111, bus_addr=i*4, bus_wdata=pattern(i), clear the timeout counter, and go to WR_WAIT.
REQ-025 bus_enable SHALL stay 1 until a cycle with bus_ready=1 and SHALL be 0 in the following cycle.
REQ-026 A WR_WAIT completion SHALL increment i; at i=ADDR_WORDS-1 it SHALL reset i to 0 and go to RD_REQ, otherwise to WR_REQ.
REQ-027 RD_REQ SHALL issue a read (bus_wr_en=0) to i*4 and go to RD_WAIT; completion SHALL latch bus_rdata and go to CHECK.
REQ-028 CHECK SHALL compare the latched data to pattern(i); a mismatch SHALL increment err_count, set log_val=bus_addr and go to LOG; a match SHALL advance i, or go to FINAL after the last word.
REQ-029 bus_err=1 with bus_ready=1, on a read or a write, SHALL count one error and log the address; it SHALL not also count a data mismatch.
REQ-030 If bus_ready is not seen within TIMEOUT cycles, the block SHALL drop bus_enable, count one error, log {8'hEE, bus_addr[23:0]}, and continue with the next access.
REQ-031 err_count SHALL saturate at 16'hFFFF.
REQ-032 LOG SHALL pulse log_trigger for exactly one cycle and go to LOG_W1; LOG_W1 SHALL go to LOG_W2; LOG_W2 SHALL wait for log_busy=0, then resume the sweep at the next word or go to FINAL.
REQ-033 FINAL SHALL log {16'hC0DE, err_count} via the LOG handshake, then set done=1, clear busy, and return to IDLE.
REQ-034 Latency: each access completes in at least 2 cycles; a zero-error sweep with 1-cycle-ready memory SHALL take at most 6*ADDR_WORDS+10 cycles, excluding the final log.

Reset
REQ-035 rst=1 SHALL force, at the next clock edge and from any state including mid-access: state=IDLE, bus_enable=0, bus_wr_en=0, bus_addr=0, bus_wdata=0, bus_be=0, log_trigger=0, log_val=0, busy=0, done=0, err_count=0.
REQ-036 An access aborted by rst SHALL not be counted or logged.

Verification
REQ-037 Ideal memory model, ADDR_WORDS=4, pulse start -> writes of 3,4,5,6 to addresses 0,4,8,12; reads match; single log 32'hC0DE0000; done=1, err_count=0.
REQ-038 Model corrupts the word at addr 8 -> one log 32'h00000008, then 32'hC0DE0001; err_count=1.
REQ-039 Model returns bus_err with ready on the write to addr 4 -> err_count=1, log 32'h00000004, and the read of addr 4 is still issued.
REQ-040 Model never asserts ready for addr 12, TIMEOUT=255 -> bus_enable drops 255 cycles after the request, log 32'hEE00000C, and the sweep completes.
REQ-041 rst asserted during RD_WAIT with logger busy -> next cycle all outputs at reset values; a new start runs a clean sweep.
REQ-042 start pulsed while busy=1 and SEED=32'hFFFFFFFF -> start ignored; patterns wrap to FFFFFFFF,00000000,00000001,...

Source files
------------

// File: rtl/mem_sweep_tester.sv
// Memory sweep tester: writes SEED+i to every word, reads it all back, counts
// mismatches, bus faults and timeouts, and reports each one to a hex logger.
module mem_sweep_tester #(
    parameter int          ADDR_WORDS = 2048,
    parameter logic [31:0] SEED       = 32'h00000003,
    parameter int          TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        bus_enable,
    output logic        bus_wr_en,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    input  logic        bus_err,
    output logic        log_trigger,
    output logic [31:0] log_val,
    input  logic        log_busy,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_count
);
    localparam int IDX_W = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ADDR_WORDS - 1);
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, LOG, LOG_W1, LOG_W2, FINAL
    } state_t;
    typedef enum logic [1:0] {PH_WRITE, PH_READ, PH_FINAL} phase_t;

    state_t            state_q, state_d, adv_state;
    phase_t            phase_q, phase_d, adv_phase;
    logic [IDX_W-1:0]  idx_q, idx_d, adv_idx;
    logic [15:0]       tmo_q, tmo_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [15:0]       err_count_q, err_count_d, err_inc;
    logic [31:0]       log_val_q, log_val_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              bus_enable_q, bus_enable_d, bus_wr_en_q, bus_wr_en_d;
    logic [31:0]       bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic              log_trigger_q, log_trigger_d;
    logic [31:0]       cur_addr, cur_pattern;

    assign cur_addr    = 32'(idx_q) << 2;
    assign cur_pattern = SEED + 32'(idx_q);
    assign err_inc     = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            phase_q       <= PH_WRITE;
            idx_q         <= '0;
            tmo_q         <= '0;
            rdata_q       <= '0;
            err_count_q   <= '0;
            log_val_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            bus_enable_q  <= 1'b0;
            bus_wr_en_q   <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_be_q      <= '0;
            log_trigger_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            rdata_q       <= rdata_d;
            err_count_q   <= err_count_d;
            log_val_q     <= log_val_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            bus_enable_q  <= bus_enable_d;
            bus_wr_en_q   <= bus_wr_en_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_be_q      <= bus_be_d;
            log_trigger_q <= log_trigger_d;
        end
    end

    always_comb begin
        // Where the sweep goes once the current word is finished, whatever the outcome.
        adv_state = FINAL;
        adv_phase = phase_q;
        adv_idx   = idx_q;
        if (idx_q != IDX_LAST) begin
            adv_idx   = idx_q + IDX_W'(1);
            adv_state = (phase_q == PH_WRITE) ? WR_REQ : RD_REQ;
        end else if (phase_q == PH_WRITE) begin
            adv_idx   = '0;
            adv_phase = PH_READ;
            adv_state = RD_REQ;
        end

        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        rdata_d     = rdata_q;
        err_count_d = err_count_q;
        log_val_d   = log_val_q;
        busy_d      = busy_q;
        done_d      = done_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d       = '0;
                    phase_d     = PH_WRITE;
                    err_count_d = '0;
                    done_d      = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = WR_REQ;
                end
            end
            WR_REQ: begin
                tmo_d   = '0;
                state_d = WR_WAIT;
            end
            RD_REQ: begin
                tmo_d   = '0;
                state_d = RD_WAIT;
            end
            WR_WAIT, RD_WAIT: begin
                if (bus_ready) begin
                    if (bus_err) begin
                        err_count_d = err_inc;
                        log_val_d   = cur_addr;
                        state_d     = LOG;
                    end else if (state_q == WR_WAIT) begin
                        state_d = adv_state;
                        phase_d = adv_phase;
                        idx_d   = adv_idx;
                    end else begin
                        rdata_d = bus_rdata;
                        state_d = CHECK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_count_d = err_inc;
                    log_val_d   = {8'hEE, cur_addr[23:0]};
                    state_d     = LOG;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            CHECK: begin
                if (rdata_q != cur_pattern) begin
                    err_count_d = err_inc;
                    log_val_d   = cur_addr;
                    state_d     = LOG;
                end else begin
                    state_d = adv_state;
                    phase_d = adv_phase;
                    idx_d   = adv_idx;
                end
            end
            LOG:    state_d = LOG_W1;
            LOG_W1: state_d = LOG_W2;
            LOG_W2: begin
                if (!log_busy) begin
                    if (phase_q == PH_FINAL) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = adv_state;
                        phase_d = adv_phase;
                        idx_d   = adv_idx;
                    end
                end
            end
            FINAL: begin
                log_val_d = {16'hC0DE, err_count_q};
                phase_d   = PH_FINAL;
                state_d   = LOG;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus and trigger outputs are registered from the next state, so the bus is
    // driven only in the wait states and always drops for a cycle between accesses.
    always_comb begin
        bus_enable_d  = (state_d == WR_WAIT) || (state_d == RD_WAIT);
        bus_wr_en_d   = (state_d == WR_WAIT);
        bus_addr_d    = bus_enable_d ? (32'(idx_d) << 2) : 32'd0;
        bus_wdata_d   = bus_wr_en_d ? (SEED + 32'(idx_d)) : 32'd0;
        bus_be_d      = bus_enable_d ? 4'hF : 4'h0;
        log_trigger_d = (state_d == LOG);
    end

    assign bus_enable  = bus_enable_q;
    assign bus_wr_en   = bus_wr_en_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_be      = bus_be_q;
    assign log_trigger = log_trigger_q;
    assign log_val     = log_val_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_count   = err_count_q;
endmodule

// File: tb/tb_mem_sweep_tester.sv
// Bench for mem_sweep_tester: two instances (SEED=3 and SEED=FFFFFFFF) on a
// small memory/logger model, checked against a per-sweep expectation list.
module tb_mem_sweep_tester;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  start, bus_enable, bus_wr_en, bus_ready, bus_err;
    logic [1:0]  log_trigger, log_busy, busy, done;
    logic [31:0] bus_addr [2];
    logic [31:0] bus_wdata [2];
    logic [31:0] bus_rdata [2];
    logic [31:0] log_val [2];
    logic [3:0]  bus_be [2];
    logic [15:0] err_count [2];

    logic        corrupt_en, err_en, stall_en, log_hold;
    logic [31:0] corrupt_addr, err_addr, stall_addr;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [31:0] mem [AW];
        logic [2:0]  lcnt;

        mem_sweep_tester #(
            .ADDR_WORDS(AW),
            .SEED(gi == 0 ? 32'h00000003 : 32'hFFFFFFFF),
            .TIMEOUT(255)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start[gi]),
            .bus_enable(bus_enable[gi]), .bus_wr_en(bus_wr_en[gi]),
            .bus_addr(bus_addr[gi]), .bus_wdata(bus_wdata[gi]), .bus_be(bus_be[gi]),
            .bus_rdata(bus_rdata[gi]), .bus_ready(bus_ready[gi]), .bus_err(bus_err[gi]),
            .log_trigger(log_trigger[gi]), .log_val(log_val[gi]), .log_busy(log_busy[gi]),
            .busy(busy[gi]), .done(done[gi]), .err_count(err_count[gi])
        );

        assign bus_ready[gi] = bus_enable[gi] && !(stall_en && bus_addr[gi] == stall_addr);
        assign bus_err[gi]   = bus_ready[gi] && err_en && bus_wr_en[gi] && bus_addr[gi] == err_addr;
        assign bus_rdata[gi] = mem[bus_addr[gi][3:2]] ^
                               ((corrupt_en && bus_addr[gi] == corrupt_addr) ? 32'h00010000 : 32'h0);
        assign log_busy[gi]  = (lcnt != 3'd0) || log_hold;

        always_ff @(posedge clk) begin
            if (bus_enable[gi] && bus_ready[gi] && bus_wr_en[gi])
                mem[bus_addr[gi][3:2]] <= bus_wdata[gi];
            if (rst)                  lcnt <= 3'd0;
            else if (log_trigger[gi]) lcnt <= 3'd3;
            else if (lcnt != 3'd0)    lcnt <= lcnt - 3'd1;
        end
    end

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] len;
    } acc_t;

    acc_t        exp_acc [$];
    logic [31:0] exp_log [$];
    int          exp_err;
    logic [31:0] got_wdata [$];
    logic [31:0] got_raddr [$];
    logic [31:0] got_logs [$];

    int          checks, passes, sel, en_len;
    logic        en_prev, trig_prev, done_prev, log_active;
    acc_t        cur;
    logic [31:0] last_log;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // What one sweep must look like: every word written then read in order,
    // one log per faulty access, and a closing summary log.
    task automatic build_model(input logic [31:0] seed);
        acc_t        e;
        logic [31:0] a;
        logic        stl, hit;
        exp_acc.delete();
        exp_log.delete();
        exp_err = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < AW; i++) begin
                a      = 32'(i * 4);
                stl    = stall_en && a == stall_addr;
                hit    = (ph == 0) ? (err_en && a == err_addr) : (corrupt_en && a == corrupt_addr);
                e.wr   = (ph == 0);
                e.addr = a;
                e.data = seed + 32'(i);
                e.len  = stl ? 16'd255 : 16'd1;
                exp_acc.push_back(e);
                if (stl) begin
                    exp_log.push_back({8'hEE, a[23:0]});
                    exp_err++;
                end else if (hit) begin
                    exp_log.push_back(a);
                    exp_err++;
                end
            end
        end
        exp_log.push_back({16'hC0DE, 16'(exp_err)});
    endtask

    task automatic compare();
        if (rst) begin
            en_prev = 1'b0; trig_prev = 1'b0; done_prev = 1'b0; log_active = 1'b0;
            exp_acc.delete();
            exp_log.delete();
            return;
        end
        if (bus_enable[sel] && !en_prev) begin
            chk("access_expected", 32'(exp_acc.size() != 0), 32'd1);
            if (exp_acc.size() != 0) cur = exp_acc.pop_front();
            chk("access_dir", 32'(bus_wr_en[sel]), 32'(cur.wr));
            chk("access_addr", bus_addr[sel], cur.addr);
            chk("access_be", 32'(bus_be[sel]), 32'hF);
            chk("busy_during_access", 32'(busy[sel]), 32'd1);
            if (cur.wr) begin
                chk("write_data", bus_wdata[sel], cur.data);
                got_wdata.push_back(bus_wdata[sel]);
            end else begin
                got_raddr.push_back(bus_addr[sel]);
            end
            en_len = 1;
        end else if (bus_enable[sel]) begin
            en_len++;
        end else if (en_prev) begin
            chk("enable_length", 32'(en_len), 32'(cur.len));
        end
        if (log_trigger[sel]) begin
            chk("trigger_one_cycle", 32'(trig_prev), 32'd0);
            chk("log_expected", 32'(exp_log.size() != 0), 32'd1);
            if (exp_log.size() != 0) chk("log_val", log_val[sel], exp_log.pop_front());
            got_logs.push_back(log_val[sel]);
            last_log   = log_val[sel];
            log_active = 1'b1;
        end else if (log_active) begin
            chk("log_val_stable", log_val[sel], last_log);
            if (!log_busy[sel]) log_active = 1'b0;
        end
        if (done[sel] && !done_prev) begin
            chk("final_err_count", 32'(err_count[sel]), 32'(exp_err));
            chk("busy_cleared", 32'(busy[sel]), 32'd0);
            chk("all_accesses_seen", 32'(exp_acc.size()), 32'd0);
            chk("all_logs_seen", 32'(exp_log.size()), 32'd0);
        end
        en_prev   = bus_enable[sel];
        trig_prev = log_trigger[sel];
        done_prev = done[sel];
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
    endtask

    task automatic check_reset_outputs(input int k);
        chk("rst_bus_enable", 32'(bus_enable[k]), 32'd0);
        chk("rst_bus_wr_en", 32'(bus_wr_en[k]), 32'd0);
        chk("rst_bus_addr", bus_addr[k], 32'd0);
        chk("rst_bus_wdata", bus_wdata[k], 32'd0);
        chk("rst_bus_be", 32'(bus_be[k]), 32'd0);
        chk("rst_log_trigger", 32'(log_trigger[k]), 32'd0);
        chk("rst_log_val", log_val[k], 32'd0);
        chk("rst_busy", 32'(busy[k]), 32'd0);
        chk("rst_done", 32'(done[k]), 32'd0);
        chk("rst_err_count", 32'(err_count[k]), 32'd0);
    endtask

    task automatic run_sweep(input int k, input logic [31:0] seed, input logic poke_start);
        sel = k;
        build_model(seed);
        got_wdata.delete();
        got_raddr.delete();
        got_logs.delete();
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        for (int c = 0; c < 3000 && !done[k]; c++) begin
            start[k] = poke_start && (c == 5);
            tick();
        end
        start[k] = 1'b0;
        chk("done_within_bound", 32'(done[k]), 32'd1);
        tick();
        chk("done_held", 32'(done[k]), 32'd1);
    endtask

    initial begin
        checks = 0; passes = 0; sel = 0; en_len = 0;
        en_prev = 1'b0; trig_prev = 1'b0; done_prev = 1'b0; log_active = 1'b0;
        last_log = '0; cur = '0;
        rst = 1'b1; start = 2'b00; log_hold = 1'b0;
        corrupt_en = 1'b0; err_en = 1'b0; stall_en = 1'b0;
        corrupt_addr = '0; err_addr = '0; stall_addr = '0;
        repeat (3) tick();
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst = 1'b0;
        tick();

        // Ideal memory
        run_sweep(0, 32'h00000003, 1'b0);
        chk("ideal_wdata0", got_wdata[0], 32'h3);
        chk("ideal_wdata1", got_wdata[1], 32'h4);
        chk("ideal_wdata2", got_wdata[2], 32'h5);
        chk("ideal_wdata3", got_wdata[3], 32'h6);
        chk("ideal_nlogs", 32'(got_logs.size()), 32'd1);
        chk("ideal_log", got_logs[0], 32'hC0DE0000);
        chk("ideal_err", 32'(err_count[0]), 32'd0);

        // Corrupted word at address 8
        corrupt_en = 1'b1; corrupt_addr = 32'd8;
        run_sweep(0, 32'h00000003, 1'b0);
        corrupt_en = 1'b0;
        chk("corrupt_nlogs", 32'(got_logs.size()), 32'd2);
        chk("corrupt_log0", got_logs[0], 32'h00000008);
        chk("corrupt_log1", got_logs[1], 32'hC0DE0001);
        chk("corrupt_err", 32'(err_count[0]), 32'd1);

        // Bus fault on the write to address 4
        err_en = 1'b1; err_addr = 32'd4;
        run_sweep(0, 32'h00000003, 1'b0);
        err_en = 1'b0;
        chk("fault_err", 32'(err_count[0]), 32'd1);
        chk("fault_log0", got_logs[0], 32'h00000004);
        chk("fault_log1", got_logs[1], 32'hC0DE0001);
        chk("fault_read4_issued", got_raddr[1], 32'h00000004);

        // Address 12 never answers: write and read both time out
        stall_en = 1'b1; stall_addr = 32'd12;
        run_sweep(0, 32'h00000003, 1'b0);
        stall_en = 1'b0;
        chk("stall_nlogs", 32'(got_logs.size()), 32'd3);
        chk("stall_log0", got_logs[0], 32'hEE00000C);
        chk("stall_log1", got_logs[1], 32'hEE00000C);
        chk("stall_log2", got_logs[2], 32'hC0DE0002);

        // Reset in the middle of a read while the logger reports busy
        sel = 0;
        build_model(32'h00000003);
        log_hold = 1'b1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int c = 0; c < 200 && !(bus_enable[0] && !bus_wr_en[0]); c++) tick();
        chk("reached_rd_wait", 32'(bus_enable[0] && !bus_wr_en[0]), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs(0);
        rst = 1'b0;
        log_hold = 1'b0;
        tick();
        run_sweep(0, 32'h00000003, 1'b0);
        chk("after_rst_err", 32'(err_count[0]), 32'd0);
        chk("after_rst_log", got_logs[0], 32'hC0DE0000);

        // SEED wrap-around, with a start pulse ignored mid-sweep
        run_sweep(1, 32'hFFFFFFFF, 1'b1);
        chk("wrap_wdata0", got_wdata[0], 32'hFFFFFFFF);
        chk("wrap_wdata1", got_wdata[1], 32'h00000000);
        chk("wrap_wdata2", got_wdata[2], 32'h00000001);
        chk("wrap_wdata3", got_wdata[3], 32'h00000002);
        chk("wrap_nwrites", 32'(got_wdata.size()), 32'd4);
        chk("wrap_log", got_logs[0], 32'hC0DE0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
